// File: rtl/ym_pcm_bus_reader.sv
// YM2610 PCM bus servicer. Each PMPX rising edge starts one transaction:
// capture a nybble-multiplexed address through the external mux, fetch one
// byte from PCM memory (or from the one-entry cache), and write it back to
// the PAD bus as two nybbles.
//
// Handshake: mem_valid is held high with mem_addr stable while in FETCH; a
// read completes in the cycle where mem_valid and mem_ready are both high.
// mem_ready is a one-cycle pulse and is ignored outside FETCH.
// mem_valid stays high during the accepting cycle, and that same cycle
// already drives the low nybble of mem_rdata onto the PAD bus (W0).
module ym_pcm_bus_reader #(
  parameter int                ADDR_W         = 24,
  parameter logic [ADDR_W-1:0] ADDRESS_OFFSET = '0,
  parameter int                SETTLE_CYCLES  = 2,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter bit                CACHE_EN       = 1'b1,
  parameter int                COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pmpx_rose,
  input  logic [3:0]         ym_io_in,
  output logic [3:0]         ym_io_out,
  output logic               ym_io_en,
  output logic [2:0]         mux_sel,
  output logic               mux_oe_n,
  output logic               pcm_load,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_valid,
  input  logic               mem_ready,
  input  logic [7:0]         mem_rdata,
  input  logic               cache_flush,
  output logic               busy,
  input  logic               count_reset,
  output logic [COUNT_W-1:0] overrun_count,
  output logic [COUNT_W-1:0] timeout_count,
  output logic [COUNT_W-1:0] hit_count,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_FETCH, S_WRITE} state_e;

  localparam int PH_W = $clog2(SETTLE_CYCLES + 7);
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // ADDR phase numbers (T1 = 1); the settle gap sits between PH_C2 and PH_C3
  localparam logic [PH_W-1:0] PH_C0   = PH_W'(1);
  localparam logic [PH_W-1:0] PH_C1   = PH_W'(2);
  localparam logic [PH_W-1:0] PH_C2   = PH_W'(3);
  localparam logic [PH_W-1:0] PH_SETL = PH_W'(2 + SETTLE_CYCLES);
  localparam logic [PH_W-1:0] PH_C3   = PH_W'(3 + SETTLE_CYCLES);
  localparam logic [PH_W-1:0] PH_C4   = PH_W'(4 + SETTLE_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(5 + SETTLE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  logic [PH_W-1:0]     ph_q;
  logic [1:0]          wph_q;
  logic [TO_W-1:0]     tmo_q;
  logic [19:0]         cap_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          byte_q;
  logic                c_valid_q;
  logic [ADDR_W-1:0]   c_tag_q;
  logic [7:0]          c_data_q;
  logic [COUNT_W-1:0]  ovr_cnt_q, tmo_cnt_q, hit_cnt_q;

  logic [23:0]         cap_full_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                last_cap, hit_d, fetch_done, fetch_tmo, overrun;

  // Address completion, cache lookup and per-cycle events
  always_comb begin
    cap_full_d = {ym_io_in, cap_q};
    mem_addr_d = cap_full_d[ADDR_W-1:0] + ADDRESS_OFFSET;
    last_cap   = (state_q == S_ADDR) && (ph_q == PH_LAST);
    hit_d      = CACHE_EN && c_valid_q && (mem_addr_d == c_tag_q);
    fetch_done = (state_q == S_FETCH) && mem_ready;
    fetch_tmo  = (state_q == S_FETCH) && !mem_ready && (tmo_q == TO_LAST);
    overrun    = pmpx_rose && (state_q != S_IDLE);
  end

  // Transaction FSM, address capture, cache entry and status counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      wph_q      <= '0;
      tmo_q      <= '0;
      cap_q      <= '0;
      mem_addr_q <= '0;
      byte_q     <= '0;
      c_valid_q  <= 1'b0;
      c_tag_q    <= '0;
      c_data_q   <= '0;
      ovr_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      hit_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pmpx_rose) begin
            state_q <= S_ADDR;
            ph_q    <= PH_C0;
          end
        end
        S_ADDR: begin
          ph_q <= ph_q + 1'b1;
          if (ph_q == PH_C0) cap_q[3:0]   <= ym_io_in;
          if (ph_q == PH_C1) cap_q[7:4]   <= ym_io_in;
          if (ph_q == PH_C2) cap_q[11:8]  <= ym_io_in;
          if (ph_q == PH_C3) cap_q[15:12] <= ym_io_in;
          if (ph_q == PH_C4) cap_q[19:16] <= ym_io_in;
          if (last_cap) begin
            mem_addr_q <= mem_addr_d;
            tmo_q      <= '0;
            if (hit_d) begin
              state_q <= S_WRITE;
              wph_q   <= 2'd0;
              byte_q  <= c_data_q;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            byte_q  <= mem_rdata;
            state_q <= S_WRITE;
            wph_q   <= 2'd1;
          end else if (fetch_tmo) begin
            byte_q  <= 8'h80;
            state_q <= S_WRITE;
            wph_q   <= 2'd0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          if (wph_q == 2'd3) state_q <= S_IDLE;
          else               wph_q   <= wph_q + 1'b1;
        end
      endcase

      // Flush wins over a fill landing in the same cycle
      if (cache_flush)     c_valid_q <= 1'b0;
      else if (fetch_done) c_valid_q <= 1'b1;
      if (fetch_done) begin
        c_tag_q  <= mem_addr_q;
        c_data_q <= mem_rdata;
      end

      if (count_reset) begin
        ovr_cnt_q <= '0;
        tmo_cnt_q <= '0;
        hit_cnt_q <= '0;
      end else begin
        if (overrun && (ovr_cnt_q != '1))              ovr_cnt_q <= ovr_cnt_q + 1'b1;
        if (fetch_tmo && (tmo_cnt_q != '1))            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        if (last_cap && hit_d && (hit_cnt_q != '1))    hit_cnt_q <= hit_cnt_q + 1'b1;
      end
    end
  end

  // Bus outputs decoded from state (and pmpx_rose for T0); forced idle in reset
  always_comb begin
    mux_sel   = 3'b000;
    mux_oe_n  = 1'b1;
    ym_io_en  = 1'b0;
    ym_io_out = 4'h0;
    pcm_load  = 1'b0;
    mem_valid = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      busy = pmpx_rose || (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (pmpx_rose) begin
            mux_sel  = 3'b010;
            mux_oe_n = 1'b0;
          end
        end
        S_ADDR: begin
          mux_oe_n = 1'b0;
          if (ph_q == PH_C0)        mux_sel = 3'b110;
          else if (ph_q == PH_C1)   mux_sel = 3'b011;
          else if (ph_q <= PH_SETL) mux_sel = 3'b010;
          else if (ph_q == PH_C3)   mux_sel = 3'b110;
          else                      mux_sel = 3'b011;
        end
        S_FETCH: begin
          mem_valid = 1'b1;
          if (mem_ready) begin
            ym_io_en  = 1'b1;
            mux_sel   = 3'b101;
            ym_io_out = mem_rdata[3:0];
            pcm_load  = 1'b1;
          end
        end
        default: begin
          ym_io_en = 1'b1;
          case (wph_q)
            2'd0:    begin mux_sel = 3'b101; ym_io_out = byte_q[3:0]; pcm_load = 1'b1; end
            2'd1:    begin mux_sel = 3'b100; ym_io_out = byte_q[3:0]; pcm_load = 1'b1; end
            2'd2:    begin mux_sel = 3'b100; ym_io_out = byte_q[7:4]; pcm_load = 1'b1; end
            default: begin mux_sel = 3'b100; ym_io_out = byte_q[7:4]; pcm_load = 1'b0; end
          endcase
        end
      endcase
    end
  end

  assign mem_addr      = mem_addr_q;
  assign overrun_count = ovr_cnt_q;
  assign timeout_count = tmo_cnt_q;
  assign hit_count     = hit_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ym_pcm_bus_reader.sv
// Bench for ym_pcm_bus_reader: directed and randomized reads against a
// transaction-level model (address arithmetic, cache entry, counters).
module tb_ym_pcm_bus_reader;

  localparam int          S    = 3;
  localparam int          TO   = 4;
  localparam int          AW   = 20;
  localparam logic [19:0] OFF  = 20'hFFFF0;
  localparam int          CMAX = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pmpx_rose = 1'b0;
  logic [3:0]  ym_io_in = 4'h0;
  logic [3:0]  ym_io_out;
  logic        ym_io_en;
  logic [2:0]  mux_sel;
  logic        mux_oe_n;
  logic        pcm_load;
  logic [19:0] mem_addr;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        cache_flush = 1'b0;
  logic        busy;
  logic        count_reset = 1'b0;
  logic [2:0]  overrun_count, timeout_count, hit_count;
  logic [1:0]  dut_state;

  ym_pcm_bus_reader #(
    .ADDR_W(AW), .ADDRESS_OFFSET(OFF), .SETTLE_CYCLES(S),
    .TIMEOUT_CYCLES(TO), .CACHE_EN(1'b1), .COUNT_W(3)
  ) dut (
    .clk(clk), .reset(reset), .pmpx_rose(pmpx_rose), .ym_io_in(ym_io_in),
    .ym_io_out(ym_io_out), .ym_io_en(ym_io_en), .mux_sel(mux_sel),
    .mux_oe_n(mux_oe_n), .pcm_load(pcm_load), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cache_flush(cache_flush), .busy(busy), .count_reset(count_reset),
    .overrun_count(overrun_count), .timeout_count(timeout_count),
    .hit_count(hit_count), .state_o(dut_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [19:0] addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  logic [19:0] m_tag = '0;
  logic [7:0]  m_data = '0;
  int          m_hits = 0, m_tmos = 0, m_ovrs = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // mux_sel the address phase must show at cycle Tp
  function automatic logic [2:0] sel_exp(input int p);
    if (p == 0) return 3'b010;
    if (p == 1) return 3'b110;
    if (p == 2) return 3'b011;
    if (p <= 2 + S) return 3'b010;
    if (p == 3 + S) return 3'b110;
    return 3'b011;
  endfunction

  // which address nybble is captured at the end of cycle Tp (-1: none)
  function automatic int cap_idx(input int p);
    if (p == 1) return 0;
    if (p == 2) return 1;
    if (p == 3) return 2;
    if (p == 3 + S) return 3;
    if (p == 4 + S) return 4;
    if (p == 5 + S) return 5;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_hits = 0; m_tmos = 0; m_ovrs = 0;
  endtask

  // ---------------- monitors ----------------
  int         wcnt = 0;
  logic [3:0] wlo, whi;
  logic       prev_valid = 1'b0;

  // PAD write monitor: rebuilds the written byte from W0..W3
  always @(negedge clk) begin
    if (reset) begin
      wcnt = 0;
    end else begin
      case (wcnt)
        0: if (ym_io_en && mux_sel == 3'b101) begin
             check("w0_load", pcm_load, 1'b1);
             check("w0_oe_n", mux_oe_n, 1'b1);
             wlo = ym_io_out;
             wcnt = 1;
           end
        1: begin
             check("w1_sel", mux_sel, 3'b100);
             check("w1_load", pcm_load, 1'b1);
             check("w1_out", ym_io_out, wlo);
             wcnt = 2;
           end
        2: begin
             check("w2_sel", mux_sel, 3'b100);
             check("w2_load", pcm_load, 1'b1);
             check("w2_en", ym_io_en, 1'b1);
             whi = ym_io_out;
             wcnt = 3;
           end
        default: begin
             check("w3_sel", mux_sel, 3'b100);
             check("w3_load", pcm_load, 1'b0);
             check("w3_out", ym_io_out, whi);
             if (exp_q.size() == 0) check("write_unexpected", 1, 0);
             else check("write_byte", {whi, wlo}, exp_q.pop_front());
             wcnt = 0;
           end
      endcase
    end
  end

  // Memory request monitor: each new request must carry the expected address
  always @(negedge clk) begin
    if (mem_valid && !prev_valid) begin
      if (addr_q.size() == 0) check("fetch_unexpected", 1, 0);
      else check("mem_addr", mem_addr, addr_q.pop_front());
    end
    prev_valid = mem_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"}, mux_sel, 3'b000);
    check({tag, "_oe_n"}, mux_oe_n, 1'b1);
    check({tag, "_en"}, ym_io_en, 1'b0);
    check({tag, "_out"}, ym_io_out, 4'h0);
    check({tag, "_load"}, pcm_load, 1'b0);
    check({tag, "_valid"}, mem_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic check_counters();
    check("overrun_count", overrun_count, sat(m_ovrs));
    check("timeout_count", timeout_count, sat(m_tmos));
    check("hit_count", hit_count, sat(m_hits));
  endtask

  // One read: lat = cycle of mem_ready within FETCH (>= TO means timeout)
  task automatic do_read(input logic [23:0] cap, input int lat, input logic [7:0] rd,
                         input bit ovr, input bit rst_w1);
    logic [19:0] addr;
    logic [7:0]  exp_b;
    bit          hit;
    int          ci;
    addr = 20'(cap[19:0] + OFF);
    hit  = m_valid && (m_tag == addr);
    if (hit) begin
      exp_b = m_data;
      m_hits++;
    end else if (lat < TO) begin
      exp_b = rd;
    end else begin
      exp_b = 8'h80;
      m_tmos++;
    end
    if (!hit) addr_q.push_back(addr);
    if (!rst_w1) exp_q.push_back(exp_b);
    if (ovr) m_ovrs += 2;

    // T0
    step();
    pmpx_rose = 1'b1;
    ym_io_in = 4'($urandom);
    @(negedge clk);
    check("t0_busy", busy, 1'b1);
    check("t0_sel", mux_sel, sel_exp(0));
    check("t0_oe_n", mux_oe_n, 1'b0);
    // address phase T1..T5+S
    for (int p = 1; p <= 5 + S; p++) begin
      step();
      pmpx_rose = ovr && (p == 3);
      ci = cap_idx(p);
      ym_io_in = (ci >= 0) ? cap[4*ci +: 4] : 4'($urandom);
      @(negedge clk);
      check("addr_oe_n", mux_oe_n, 1'b0);
      check("addr_en", ym_io_en, 1'b0);
      if (p <= 4 + S) check("addr_sel", mux_sel, sel_exp(p));
    end
    // T6+S
    step();
    pmpx_rose = 1'b0;
    ym_io_in = 4'($urandom);
    if (hit) begin
      @(negedge clk);
      check("hit_no_fetch", mem_valid, 1'b0);
    end else if (lat < TO) begin
      for (int f = 0; f <= lat; f++) begin
        if (f > 0) step();
        mem_ready = (f == lat);
        mem_rdata = (f == lat) ? rd : 8'($urandom);
        @(negedge clk);
        check("fetch_valid", mem_valid, 1'b1);
        check("fetch_addr_hold", mem_addr, addr);
      end
      m_valid = 1'b1;
      m_tag = addr;
      m_data = rd;
    end else begin
      for (int f = 0; f < TO; f++) begin
        if (f > 0) step();
        mem_ready = 1'b0;
        @(negedge clk);
        check("fetch_valid", mem_valid, 1'b1);
      end
      step();
      mem_ready = 1'b1;               // late response must be ignored
      mem_rdata = 8'($urandom);
      @(negedge clk);
      check("timeout_drop", mem_valid, 1'b0);
    end
    // W1
    step();
    mem_ready = 1'b0;
    pmpx_rose = ovr;
    if (rst_w1) begin
      reset = 1'b1;
      @(negedge clk);
      check_idle("rst_w1");
      step();
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_w1_state_idle", busy, 1'b0);
      check_counters();
      return;
    end
    step();             // W2
    pmpx_rose = 1'b0;
    step();             // W3
    step();             // back to idle
    @(negedge clk);
    check("end_busy", busy, 1'b0);
    check("end_oe_n", mux_oe_n, 1'b1);
    check_counters();
  endtask

  task automatic rst_t4(input logic [23:0] cap);
    step();
    pmpx_rose = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      step();
      pmpx_rose = 1'b0;
      ym_io_in = cap[4*(p-1) +: 4];
    end
    step();             // T4
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst_t4");
    step();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_t4_state_idle", busy, 1'b0);
    check_counters();
  endtask

  task automatic do_flush();
    step();
    cache_flush = 1'b1;
    step();
    cache_flush = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_count_reset();
    step();
    count_reset = 1'b1;
    step();
    count_reset = 1'b0;
    m_hits = 0; m_tmos = 0; m_ovrs = 0;
    @(negedge clk);
    check_counters();
  endtask

  // ---------------- stimulus ----------------
  logic [23:0] pool [4];

  initial begin
    // reset: outputs idle even with pmpx_rose high
    reset = 1'b1;
    pmpx_rose = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    step();
    pmpx_rose = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
    check_counters();

    // basic read, 3-cycle ready
    do_read(24'h654321, 2, 8'hA7, 1'b0, 1'b0);
    // same address hits the cache
    do_read(24'h654321, 1, 8'h11, 1'b0, 1'b0);
    // after a flush the same address fetches again
    do_flush();
    do_read(24'h654321, 1, 8'h3C, 1'b0, 1'b0);
    // timeout, late ready ignored
    do_read(24'h0ABCDE, TO, 8'h55, 1'b0, 1'b0);
    // overruns at T3 and W1
    do_read(24'h012345, 0, 8'h96, 1'b1, 1'b0);
    // offset wrap: 0x00020 + 0xFFFF0 -> 0x00010
    do_read(24'h000020, 0, 8'hE1, 1'b0, 1'b0);
    // reset at T4
    rst_t4(24'h000020);
    // fill, then reset at W1 of a hit, then the same address misses
    do_read(24'h0F00F0, 1, 8'h5A, 1'b0, 1'b0);
    do_read(24'h0F00F0, 0, 8'h00, 1'b0, 1'b1);
    do_read(24'h0F00F0, 0, 8'hC3, 1'b0, 1'b0);

    // randomized traffic over a small address pool so hits occur
    for (int i = 0; i < 4; i++) pool[i] = 24'($urandom);
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) do_flush();
      if (r == 1) do_count_reset();
      do_read(pool[$urandom_range(0, 3)], $urandom_range(0, TO + 1),
              8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ym_pcm_bus_reader.md
Name: ym_pcm_bus_reader

Overview:
Parametrised next-generation YM2610 PCM bus servicer. On each PMPX rising edge it does four things: captures a 24-bit nybble-multiplexed address through the external 74-series mux, fetches one byte from PCM memory, writes the byte back as two nybbles, and returns to idle. Over the previous reader it adds a configurable settle gap, a configurable used-address width, a memory timeout with fallback data, a single-entry last-byte cache, overrun detection and saturating status counters. It sits between the PMPX edge detector and the PCM memory arbiter, one instance per PCM bus.

Parameters:
ADDR_W, 24, used address bits (8..24, multiple of 4); mem_addr = captured[ADDR_W-1:0] + ADDRESS_OFFSET
ADDRESS_OFFSET, 0, ADDR_W-bit constant added to the captured address
SETTLE_CYCLES, 2, cycles (>=1) that PAD3_0 stays selected between low and high address halves
TIMEOUT_CYCLES, 64, max cycles mem_valid is held before abort (>=2)
CACHE_EN, 1, 1 = skip memory when the address equals the last fetched address
COUNT_W, 16, status counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
pmpx_rose  in  1  one-cycle pulse, PMPX rising edge
ym_io_in  in  4  mux output nybble
ym_io_out  out  4  nybble driven to YM PAD bus
ym_io_en  out  1  ym_io_out drive enable
mux_sel  out  3  external mux select
mux_oe_n  out  1  mux output enable, active low
pcm_load  out  1  PAD latch enable
mem_addr  out  ADDR_W  PCM memory byte address
mem_valid  out  1  read request
mem_ready  in  1  read data valid (one-cycle pulse)
mem_rdata  in  8  read data
cache_flush  in  1  invalidate cache entry
busy  out  1  pmpx_rose OR state != IDLE
count_reset  in  1  clear all counters
overrun_count  out  COUNT_W  pmpx_rose seen while busy
timeout_count  out  COUNT_W  aborted reads
hit_count  out  COUNT_W  cache hits

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: next state IDLE; cache invalid; counters 0.
- Output values while reset is high (combinational): mux_sel=0, mux_oe_n=1, ym_io_en=0, ym_io_out=0, pcm_load=0, mem_valid=0, busy=0.
- Reset mid-operation: no write completes.
- Idle values: same as the reset output values.
- Output timing: outputs are combinational from state and pmpx_rose, so T0 (the pmpx_rose cycle) is driven the same cycle.
- States: IDLE -> ADDR -> FETCH | (cache hit) WRITE -> WRITE -> IDLE.
- ADDR phase: mux_oe_n=0, ym_io_en=0. Let S=SETTLE_CYCLES.
- mux_sel schedule: T0=010; T1=110; T2=011; T3..T2+S=010; T3+S=110; T4+S=011.
- Address capture (ym_io_in sampled at the end of the cycle): [3:0]@T1, [7:4]@T2, [11:8]@T3, [15:12]@T3+S, [19:16]@T4+S, [23:20]@T5+S.
- Cache decision at T6+S: if CACHE_EN, entry valid and mem_addr == tag, go to WRITE with the cached byte and increment hit_count. Otherwise go to FETCH.
- FETCH: mem_valid=1 from T6+S; mem_addr held stable.
- On mem_ready the same cycle (call it W0) is the first WRITE cycle; it drives mem_rdata[3:0] directly. The byte is latched and the cache tag/data are updated.
- FETCH timeout: if no mem_ready after TIMEOUT_CYCLES cycles of mem_valid, drop mem_valid, substitute byte 0x80, increment timeout_count, cache unchanged, go to WRITE.
- mem_ready outside FETCH is ignored.
- WRITE phase: 4 cycles, ym_io_en=1, mux_oe_n=1.
  - W0: sel=101, out=lo, load=1
  - W1: sel=100, out=lo, load=1
  - W2: sel=100, out=hi, load=1
  - W3: sel=100, out=hi, load=0
  - Return to IDLE after W3.
- pmpx_rose while not IDLE: ignored, overrun_count++.
- cache_flush: invalidates the entry next cycle; flush has priority over a same-cycle fill.
- Counters saturate at all-ones. count_reset clears them and has priority over increments.
- Address arithmetic: the ADDR_W-bit sum wraps modulo 2^ADDR_W.

Test Plan:
- Basic read: S=2, mux returns nybbles 1,2,3,4,5,6 in capture order → mem_addr=0x654321 at T8; mem_rdata=0xA7 with a 3-cycle ready → W0 out=7 sel=101, W2 out=A, busy drops after W3.
- Cache hit: repeat the same address → mem_valid never asserts, writes 0xA7, hit_count=1. After cache_flush, the same address → mem_valid asserts.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held low → mem_valid high exactly 4 cycles; writes lo=0, hi=8; timeout_count=1; a late mem_ready is ignored.
- Overrun: pmpx_rose at T3 and at W1 → overrun_count=2, sequence unchanged.
- Offset and width: ADDR_W=20, ADDRESS_OFFSET=0xFFFF0, captured 0x00020 → mem_addr=0x00010 (wrap).
- Reset at T4 and at W1 → outputs idle the same cycle, IDLE next cycle, a subsequent read of the cached address misses.
